// File: rtl/lut_neuron_table_loader_pkg.sv
// Shared types and helpers for the runtime-loadable LUT neuron.
// Default-geometry constants mirror the generated fixed-ROM neurons.
package lut_neuron_table_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    READY
  } state_t;

  localparam int IN_BITS_DEF      = 8;
  localparam int OUT_BITS_DEF     = 2;
  localparam int WORD_ENTRIES_DEF = 4;
  localparam int DEPTH            = 2 ** IN_BITS_DEF;
  localparam int BEATS            = DEPTH / WORD_ENTRIES_DEF;
  localparam int BEAT_BITS        = $clog2(BEATS);

  // A single-beat table still needs a one-bit counter.
  function automatic int beat_bits(input int in_bits, input int word_entries);
    int b;
    b = $clog2((2 ** in_bits) / word_entries);
    return (b < 1) ? 1 : b;
  endfunction

  function automatic int slice_offset(input int k, input int out_bits);
    return k * out_bits;
  endfunction

endpackage

// File: rtl/lut_neuron_table_loader_if.sv
// Configuration stream and lookup port bundle for the loadable LUT neuron.
interface lut_neuron_table_loader_if #(
  parameter int IN_BITS      = 8,
  parameter int OUT_BITS     = 2,
  parameter int WORD_ENTRIES = 4
);

  logic                             cfg_start;
  logic                             cfg_valid;
  logic                             cfg_ready;
  logic [WORD_ENTRIES*OUT_BITS-1:0] cfg_data;
  logic                             cfg_done;
  logic                             lookup_dropped;
  logic                             in_valid;
  logic [IN_BITS-1:0]               in_data;
  logic                             out_valid;
  logic [OUT_BITS-1:0]              out_data;

  modport master (
    output cfg_start, cfg_valid, cfg_data, in_valid, in_data,
    input  cfg_ready, cfg_done, lookup_dropped, out_valid, out_data
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_data, in_valid, in_data,
    output cfg_ready, cfg_done, lookup_dropped, out_valid, out_data
  );

endinterface

// File: rtl/lut_table_ram.sv
// Distributed-RAM truth table: one wide write port per config beat and
// one registered read port that returns the neuron output code.
module lut_table_ram
  import lut_neuron_table_loader_pkg::*;
#(
  parameter int IN_BITS      = 8,
  parameter int OUT_BITS     = 2,
  parameter int WORD_ENTRIES = 4,
  parameter int BEAT_W       = 6
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             we,
  input  logic [BEAT_W-1:0]                wbeat,
  input  logic [WORD_ENTRIES*OUT_BITS-1:0] wdata,
  input  logic                             re,
  input  logic [IN_BITS-1:0]               raddr,
  output logic [OUT_BITS-1:0]              rdata
);

  localparam int TBL_DEPTH = 2 ** IN_BITS;

  (* ram_style = "distributed" *) logic [OUT_BITS-1:0] mem [TBL_DEPTH];

  // Contents are deliberately left unreset so the array maps onto LUT RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < WORD_ENTRIES; k++) begin
        mem[IN_BITS'(int'(wbeat) * WORD_ENTRIES + k)] <= wdata[slice_offset(k, OUT_BITS) +: OUT_BITS];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/lut_neuron_table_loader.sv
// Runtime-programmable LUT neuron: loads its truth table over a valid/ready
// stream, then answers lookups with one cycle of latency.
module lut_neuron_table_loader
  import lut_neuron_table_loader_pkg::*;
#(
  parameter int IN_BITS      = 8,
  parameter int OUT_BITS     = 2,
  parameter int WORD_ENTRIES = 4
) (
  input logic                      clk,
  input logic                      rst,
  lut_neuron_table_loader_if.slave bus
);

  localparam int NBEATS = (2 ** IN_BITS) / WORD_ENTRIES;
  localparam int NBB    = beat_bits(IN_BITS, WORD_ENTRIES);

  state_t         state;
  state_t         state_next;
  logic [NBB-1:0] beat_cnt;
  logic           handshake;
  logic           last_beat;
  logic           lookup_ok;
  logic           out_valid_q;
  logic           dropped_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A beat coinciding with cfg_start is discarded so the restart begins cleanly at beat 0.
  always_comb begin
    state_next    = state;
    bus.cfg_ready = (state == LOAD);
    bus.cfg_done  = (state == READY);
    handshake     = bus.cfg_valid && (state == LOAD) && !bus.cfg_start;
    last_beat     = (beat_cnt == NBB'(NBEATS - 1));
    lookup_ok     = bus.in_valid && (state == READY);
    case (state)
      IDLE: begin
        if (bus.cfg_start) state_next = LOAD;
      end
      LOAD: begin
        if (bus.cfg_start)               state_next = LOAD;
        else if (handshake && last_beat) state_next = READY;
      end
      READY: begin
        if (bus.cfg_start) state_next = LOAD;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt    <= '0;
      out_valid_q <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      out_valid_q <= lookup_ok;
      if (bus.cfg_start) begin
        beat_cnt <= '0;
      end else if (handshake) begin
        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      end
      if (bus.cfg_start) begin
        dropped_q <= 1'b0;
      end else if (bus.in_valid && (state != READY)) begin
        dropped_q <= 1'b1;
      end
    end
  end

  assign bus.out_valid      = out_valid_q;
  assign bus.lookup_dropped = dropped_q;

  lut_table_ram #(
    .IN_BITS      (IN_BITS),
    .OUT_BITS     (OUT_BITS),
    .WORD_ENTRIES (WORD_ENTRIES),
    .BEAT_W       (NBB)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (handshake),
    .wbeat (beat_cnt),
    .wdata (bus.cfg_data),
    .re    (lookup_ok),
    .raddr (bus.in_data),
    .rdata (bus.out_data)
  );

endmodule

// File: doc/lut_neuron_table_loader.md
Name: lut_neuron_table_loader

Overview:
- Runtime-programmable counterpart to the generated fixed-ROM LUT neurons: instead of a hard-coded case table, the truth table is written in over a valid/ready configuration stream.
- The written table is stored in distributed RAM and is then served to lookups with the same address encoding as the fixed neurons: the packed input word is the table index, and the entry is the neuron output code.
- Used for in-field neuron updates and for bench cross-checking against the generated ROM neurons.

Parameters:
- IN_BITS, default 8: packed neuron input width; table depth is 2**IN_BITS.
- OUT_BITS, default 2: output code width per table entry.
- WORD_ENTRIES, default 4: number of table entries carried per configuration beat; must be a power of two that divides 2**IN_BITS.

Ports:
- clk, input, 1: the only clock.
- rst, input, 1: synchronous, active-high reset.
- cfg_start, input, 1: single-cycle pulse that begins or restarts a table load.
- cfg_valid, input, 1: configuration beat valid.
- cfg_ready, output, 1: block accepts a configuration beat this cycle.
- cfg_data, input, WORD_ENTRIES*OUT_BITS: packed entries; slice k is table entry beat*WORD_ENTRIES+k.
- cfg_done, output, 1: level, high when a complete table has been loaded.
- lookup_dropped, output, 1: sticky flag set when a lookup arrives while the table is not loaded.
- in_valid, input, 1: lookup request.
- in_data, input, IN_BITS: lookup index, identical to the M0 encoding of the fixed neurons.
- out_valid, output, 1: lookup result valid.
- out_data, output, OUT_BITS: looked-up code.

Behaviour:
- Clocking and reset: one clock domain; reset is synchronous and active-high on rst.
  - Reset values: state IDLE, beat counter 0, cfg_ready 0, cfg_done 0, lookup_dropped 0, out_valid 0, out_data 0.
  - Table contents are not reset and are undefined until a load completes.
- States: IDLE, LOAD, READY.
- IDLE: on cfg_start go to LOAD with beat counter 0.
- LOAD:
  - cfg_ready = 1, driven combinationally from state.
  - A handshake is cfg_valid && cfg_ready. On a handshake, all WORD_ENTRIES slices are written to the table in the same cycle and the beat counter increments.
  - cfg_valid low stalls the load with no timeout.
  - Last beat is beat counter == 2**IN_BITS/WORD_ENTRIES - 1 (63 with defaults). On the last handshake go to READY; cfg_done rises the next cycle.
- READY:
  - cfg_ready = 0, cfg_done = 1.
  - in_valid gives out_valid = 1 on the next cycle, with out_data = table[in_data]. Latency is exactly 1; back-to-back lookups give one result per cycle.
- cfg_start in LOAD or READY:
  - Restarts the load: next state LOAD, beat counter 0, cfg_done cleared next cycle.
  - Already-written entries are kept but are not valid until the new load completes.
  - A beat presented in the same cycle as cfg_start is ignored.
- Lookups when state is not READY: in_valid gives out_valid = 0 next cycle, out_data holds its last value, and lookup_dropped is set.
- lookup_dropped clears only on rst or cfg_start.
- Simultaneous events:
  - in_valid and cfg_start in READY: the lookup is served from the current contents, then the block enters LOAD.
  - in_valid in the same cycle as the final load beat: the lookup is dropped, because the state is still LOAD.
- out_valid is low on every cycle with no accepted lookup.
- Reset mid-load returns to IDLE; cfg_done = 0 until a complete reload.
- No read/write collision is possible: writes occur only in LOAD and reads only in READY.

Decomposition:
- Shared package:
  - state enum {IDLE, LOAD, READY}.
  - Derived constants DEPTH = 2**IN_BITS, BEATS = DEPTH/WORD_ENTRIES, BEAT_BITS = log2(BEATS).
  - Helper for the slice offset k*OUT_BITS.
- One sub-module, lut_table_ram:
  - DEPTH x OUT_BITS distributed RAM with rom_style-equivalent distributed attribute.
  - WORD_ENTRIES-wide synchronous write port, written at base address beat*WORD_ENTRIES.
  - One registered read port.
- The top holds the FSM, counters, flags and the handshake.

Test Plan:
- Reset check: assert rst for 3 cycles → cfg_ready = 0, cfg_done = 0, out_valid = 0, out_data = 2'b00, lookup_dropped = 0.
- Full load and lookups: cfg_start, then 64 beats of cfg_data = 8'b11_10_01_00 with no gaps → cfg_done = 1 one cycle after beat 63. Lookups then return:
  - in_data = 8'h07 → out_data = 2'b11 one cycle later.
  - 8'h02 → 2'b10.
  - 8'hFC → 2'b00.
- Backpressure and pipelining: load with cfg_valid low on every other cycle, entry i = i[7:6] → load completes after 64 handshakes. Then a back-to-back lookup stream 8'h00, 8'h40, 8'h80, 8'hC0 → out_data 00, 01, 10, 11 on 4 consecutive cycles with out_valid held high.
- Restart mid-load: cfg_start after 10 beats, then 64 fresh beats of all 8'hFF → cfg_done only after the 64th fresh beat; any lookup returns 2'b11.
- Dropped lookups: in_valid = 1 during LOAD (index 8'h05) → out_valid stays 0 and lookup_dropped = 1. It stays 1 through READY and clears on the next cfg_start.
- Reset mid-load: rst after 30 beats → IDLE, cfg_done = 0. A lookup now is dropped; a full reload then works as in the full load scenario.
